// File: rtl/inst_cache_ctrl_if.sv
// Bus bundle for the instruction cache controller: fetch port (ufp),
// memory/arbiter port (dfp) and the external flip-flop array port.
// master = controller view, slave = environment (fetch, arbiter, arrays).
interface inst_cache_ctrl_if #(
  parameter int S_INDEX = 4,
  parameter int TAG_W   = 32 - 5 - S_INDEX
);
  // fetch side
  logic               ufp_req;
  logic [31:0]        ufp_addr;
  logic               ufp_ready;
  logic               ufp_resp;
  logic [31:0]        ufp_rdata;
  // memory side
  logic               dfp_read;
  logic [31:0]        dfp_addr;
  logic               dfp_rvalid;
  logic [63:0]        dfp_rdata;
  // array side
  logic               arr_csb;
  logic               arr_web;
  logic [S_INDEX-1:0] arr_addr;
  logic [TAG_W-1:0]   arr_tag_din;
  logic               arr_valid_din;
  logic [255:0]       arr_data_din;
  logic [TAG_W-1:0]   arr_tag_dout;
  logic               arr_valid_dout;
  logic [255:0]       arr_data_dout;

  modport master (
    input  ufp_req, ufp_addr, dfp_rvalid, dfp_rdata,
           arr_tag_dout, arr_valid_dout, arr_data_dout,
    output ufp_ready, ufp_resp, ufp_rdata, dfp_read, dfp_addr,
           arr_csb, arr_web, arr_addr, arr_tag_din, arr_valid_din, arr_data_din
  );

  modport slave (
    output ufp_req, ufp_addr, dfp_rvalid, dfp_rdata,
           arr_tag_dout, arr_valid_dout, arr_data_dout,
    input  ufp_ready, ufp_resp, ufp_rdata, dfp_read, dfp_addr,
           arr_csb, arr_web, arr_addr, arr_tag_din, arr_valid_din, arr_data_din
  );
endinterface

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped instruction cache controller (32-byte lines, 4 x 64-bit refill).
// Optional feature macro: INST_CACHE_FLUSH_EN adds a flush input and a FLUSH
// state that invalidates every set, one per cycle.
// Array controls are combinational so the array captures the index on the same
// edge a request is accepted, giving a one-cycle hit latency.
module inst_cache_ctrl #(
  parameter int S_INDEX = 4,
  parameter int TAG_W   = 32 - 5 - S_INDEX
) (
  input  logic clk0,
  input  logic rst0_n,
`ifdef INST_CACHE_FLUSH_EN
  input  logic flush,
`endif
  inst_cache_ctrl_if.master bus
);

`ifdef INST_CACHE_FLUSH_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    REFILL  = 3'd2,
    WRITE   = 3'd3,
    FLUSH   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    REFILL  = 3'd2,
    WRITE   = 3'd3
  } state_t;
`endif

  state_t             state_r, state_nxt;
  logic [31:2]        addr_r;      // latched word address of the request in flight
  logic [1:0]         cnt_r;       // refill beat counter
  logic [255:0]       line_r;      // refill line buffer
  logic               stale_r;     // array holds a different set than addr_r
  logic               stale_nxt;
  logic               addr_ld;

  logic [TAG_W-1:0]   addr_tag;
  logic [S_INDEX-1:0] addr_idx;
  logic [S_INDEX-1:0] req_idx;
  logic               hit;
  logic               beat_ok;

  logic               ready_c, resp_c, dfp_read_c, csb_c, web_c, valid_din_c;
  logic [31:0]        rdata_c;
  logic [S_INDEX-1:0] arr_addr_c;
  logic [TAG_W-1:0]   tag_din_c;
  logic [255:0]       data_din_c;

  logic               unused_addr_lsb;
  assign unused_addr_lsb = ^bus.ufp_addr[1:0];

`ifdef INST_CACHE_FLUSH_EN
  logic [S_INDEX-1:0] flush_idx_r;
`endif

  // Select one 32-bit word of a line by word offset.
  function automatic logic [31:0] pick_word(input logic [255:0] line, input logic [2:0] w);
    return line[{w, 5'd0} +: 32];
  endfunction

  assign addr_tag = addr_r[31:5+S_INDEX];
  assign addr_idx = addr_r[4+S_INDEX:5];
  assign req_idx  = bus.ufp_addr[4+S_INDEX:5];
  assign hit      = bus.arr_valid_dout && (bus.arr_tag_dout == addr_tag);
  assign beat_ok  = (state_r == REFILL) && bus.dfp_rvalid;

  // State register, request latch, beat counter and stale-read flag.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_r <= IDLE;
      addr_r  <= 30'd0;
      cnt_r   <= 2'd0;
      stale_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      stale_r <= stale_nxt;
      if (addr_ld) begin
        addr_r <= bus.ufp_addr[31:2];
      end
      if (beat_ok) begin
        cnt_r <= cnt_r + 2'd1;
      end
    end
  end

  // Line buffer collects refill beats in ascending order; contents need no reset.
  always_ff @(posedge clk0) begin
    if (beat_ok) begin
      line_r[{cnt_r, 6'd0} +: 64] <= bus.dfp_rdata;
    end
  end

`ifdef INST_CACHE_FLUSH_EN
  // Flush sweep index, held at zero outside FLUSH.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      flush_idx_r <= '0;
    end else if (state_r == FLUSH) begin
      flush_idx_r <= flush_idx_r + {{(S_INDEX-1){1'b0}}, 1'b1};
    end else begin
      flush_idx_r <= '0;
    end
  end
`endif

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state_r;
    stale_nxt   = stale_r;
    addr_ld     = 1'b0;
    ready_c     = 1'b0;
    resp_c      = 1'b0;
    rdata_c     = 32'd0;
    dfp_read_c  = 1'b0;
    csb_c       = 1'b1;
    web_c       = 1'b1;
    arr_addr_c  = addr_idx;
    tag_din_c   = addr_tag;
    valid_din_c = 1'b0;
    data_din_c  = line_r;
    case (state_r)
      IDLE: begin
`ifdef INST_CACHE_FLUSH_EN
        if (flush) begin
          state_nxt = FLUSH;
        end else
`endif
        if (bus.ufp_req && rst0_n) begin
          ready_c    = 1'b1;
          addr_ld    = 1'b1;
          csb_c      = 1'b0;
          arr_addr_c = req_idx;
          stale_nxt  = 1'b0;
          state_nxt  = COMPARE;
        end else begin
          ready_c = 1'b1;
        end
      end
      COMPARE: begin
        if (stale_r) begin
          // request accepted during WRITE for another set: read its set now
          csb_c     = 1'b0;
          stale_nxt = 1'b0;
        end else if (hit) begin
          resp_c  = 1'b1;
          rdata_c = pick_word(bus.arr_data_dout, addr_r[4:2]);
          ready_c = 1'b1;
          if (bus.ufp_req) begin
            addr_ld    = 1'b1;
            csb_c      = 1'b0;
            arr_addr_c = req_idx;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          dfp_read_c = 1'b1;
          state_nxt  = REFILL;
        end
      end
      REFILL: begin
        dfp_read_c = 1'b1;
        if (beat_ok && (cnt_r == 2'd3)) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = REFILL;
        end
      end
      WRITE: begin
        csb_c       = 1'b0;
        web_c       = 1'b0;
        valid_din_c = 1'b1;
        resp_c      = 1'b1;
        rdata_c     = pick_word(line_r, addr_r[4:2]);
        ready_c     = 1'b1;
        if (bus.ufp_req) begin
          addr_ld   = 1'b1;
          stale_nxt = (req_idx != addr_idx);
          state_nxt = COMPARE;
        end else begin
          state_nxt = IDLE;
        end
      end
`ifdef INST_CACHE_FLUSH_EN
      FLUSH: begin
        csb_c       = 1'b0;
        web_c       = 1'b0;
        arr_addr_c  = flush_idx_r;
        tag_din_c   = '0;
        valid_din_c = 1'b0;
        data_din_c  = 256'd0;
        if (flush_idx_r == {S_INDEX{1'b1}}) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = FLUSH;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ufp_ready     = ready_c;
  assign bus.ufp_resp      = resp_c;
  assign bus.ufp_rdata     = rdata_c;
  assign bus.dfp_read      = dfp_read_c;
  assign bus.dfp_addr      = {addr_tag, addr_idx, 5'd0};
  assign bus.arr_csb       = csb_c;
  assign bus.arr_web       = web_c;
  assign bus.arr_addr      = arr_addr_c;
  assign bus.arr_tag_din   = tag_din_c;
  assign bus.arr_valid_din = valid_din_c;
  assign bus.arr_data_din  = data_din_c;

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Directed bench for inst_cache_ctrl with a flip-flop array model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_inst_cache_ctrl;
  localparam int S_INDEX = 4;
  localparam int TAG_W   = 23;

  localparam logic [255:0] LINE_A =
    256'h44444444_44440000_33333333_33330000_22222222_22220000_11111111_11110000;
  localparam logic [255:0] LINE_B =
    256'hAAAA0007_AAAA0006_AAAA0005_AAAA0004_AAAA0003_AAAA0002_AAAA0001_AAAA0000;

  logic clk0 = 1'b0;
  logic rst0_n;
  logic mem_clr;
  int   total;
  int   bad;
  int   resp_cnt;
  int   resp0;
`ifdef INST_CACHE_FLUSH_EN
  logic flush;
`endif

  inst_cache_ctrl_if #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) bus ();

  inst_cache_ctrl #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
`ifdef INST_CACHE_FLUSH_EN
    .flush  (flush),
`endif
    .bus    (bus.master)
  );

  always #5 clk0 = ~clk0;

  // flip-flop array model: index and write both land on the clock edge
  logic [TAG_W-1:0] tag_mem   [16];
  logic             valid_mem [16];
  logic [255:0]     data_mem  [16];
  logic [3:0]       rd_idx;

  always @(posedge clk0) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) begin
        valid_mem[i] <= 1'b0;
        tag_mem[i]   <= '0;
        data_mem[i]  <= 256'd0;
      end
      rd_idx <= 4'd0;
    end else if (!bus.arr_csb) begin
      rd_idx <= bus.arr_addr;
      if (!bus.arr_web) begin
        tag_mem[bus.arr_addr]   <= bus.arr_tag_din;
        valid_mem[bus.arr_addr] <= bus.arr_valid_din;
        data_mem[bus.arr_addr]  <= bus.arr_data_din;
      end
    end
  end

  assign bus.arr_tag_dout   = tag_mem[rd_idx];
  assign bus.arr_valid_dout = valid_mem[rd_idx];
  assign bus.arr_data_dout  = data_mem[rd_idx];

  always @(posedge clk0) begin
    if (bus.ufp_resp) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d);
    @(negedge clk0);
    bus.dfp_rvalid = 1'b1;
    bus.dfp_rdata  = d;
    #1;
    chk("beat_dfp_read", bus.dfp_read, 1'b1);
    chk("beat_resp", bus.ufp_resp, 1'b0);
  endtask

  task automatic beats_a();
    beat(64'h11111111_11110000);
    beat(64'h22222222_22220000);
    beat(64'h33333333_33330000);
    beat(64'h44444444_44440000);
  endtask

  initial begin
    total = 0; bad = 0; resp_cnt = 0; resp0 = 0;
    rst0_n = 1'b0; mem_clr = 1'b1;
    bus.ufp_req = 1'b0; bus.ufp_addr = 32'd0;
    bus.dfp_rvalid = 1'b0; bus.dfp_rdata = 64'd0;
`ifdef INST_CACHE_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge clk0);
    mem_clr = 1'b0;
    #1;
    chk("rst_ready", bus.ufp_ready, 1'b1);
    chk("rst_resp", bus.ufp_resp, 1'b0);
    chk("rst_dfp_read", bus.dfp_read, 1'b0);
    chk("rst_csb", bus.arr_csb, 1'b1);
    chk("rst_web", bus.arr_web, 1'b1);
    @(negedge clk0);
    rst0_n = 1'b1;

    // cold miss on 0x1044
    @(negedge clk0);
    bus.ufp_req = 1'b1; bus.ufp_addr = 32'h0000_1044;
    #1;
    resp0 = resp_cnt;
    chk("idle_ready", bus.ufp_ready, 1'b1);
    chk("idle_csb", bus.arr_csb, 1'b0);
    chk("idle_web", bus.arr_web, 1'b1);
    chk("idle_idx", bus.arr_addr, 4'd2);
    @(negedge clk0);
    bus.ufp_req = 1'b0;
    #1;
    chk("miss_ready", bus.ufp_ready, 1'b0);
    chk("miss_dfp_read", bus.dfp_read, 1'b1);
    chk("miss_dfp_addr", bus.dfp_addr, 32'h0000_1040);
    chk("miss_resp", bus.ufp_resp, 1'b0);
    @(negedge clk0);
    #1;
    chk("lat_dfp_read", bus.dfp_read, 1'b1);
    chk("lat_dfp_addr", bus.dfp_addr, 32'h0000_1040);
    beats_a();
    @(negedge clk0);
    bus.dfp_rvalid = 1'b0; bus.dfp_rdata = 64'd0;
    #1;
    chk("wr_csb", bus.arr_csb, 1'b0);
    chk("wr_web", bus.arr_web, 1'b0);
    chk("wr_idx", bus.arr_addr, 4'd2);
    chk("wr_tag", bus.arr_tag_din, 23'h000008);
    chk("wr_valid", bus.arr_valid_din, 1'b1);
    chk("wr_data", bus.arr_data_din, LINE_A);
    chk("wr_resp", bus.ufp_resp, 1'b1);
    chk("wr_rdata", bus.ufp_rdata, 32'h1111_1111);
    chk("wr_dfp_read", bus.dfp_read, 1'b0);

    // hit on 0x1048
    @(negedge clk0);
    bus.ufp_req = 1'b1; bus.ufp_addr = 32'h0000_1048;
    #1;
    chk("hit_idle_resp", bus.ufp_resp, 1'b0);
    chk("hit_idle_ready", bus.ufp_ready, 1'b1);
    @(negedge clk0);
    bus.ufp_req = 1'b0;
    #1;
    chk("hit_resp", bus.ufp_resp, 1'b1);
    chk("hit_rdata", bus.ufp_rdata, 32'h2222_0000);
    chk("hit_dfp_read", bus.dfp_read, 1'b0);
    chk("miss_resp_once", resp_cnt - resp0, 32'd1);

    // back-to-back hits
    @(negedge clk0);
    bus.ufp_req = 1'b1; bus.ufp_addr = 32'h0000_1040;
    #1;
    chk("b2b_ready0", bus.ufp_ready, 1'b1);
    @(negedge clk0);
    bus.ufp_addr = 32'h0000_1044;
    #1;
    chk("b2b_resp1", bus.ufp_resp, 1'b1);
    chk("b2b_rdata1", bus.ufp_rdata, 32'h1111_0000);
    chk("b2b_ready1", bus.ufp_ready, 1'b1);
    @(negedge clk0);
    bus.ufp_addr = 32'h0000_1048;
    #1;
    chk("b2b_rdata2", bus.ufp_rdata, 32'h1111_1111);
    chk("b2b_ready2", bus.ufp_ready, 1'b1);
    @(negedge clk0);
    bus.ufp_addr = 32'h0000_104C;
    #1;
    chk("b2b_rdata3", bus.ufp_rdata, 32'h2222_0000);
    chk("b2b_ready3", bus.ufp_ready, 1'b1);
    @(negedge clk0);
    bus.ufp_req = 1'b0;
    #1;
    chk("b2b_resp4", bus.ufp_resp, 1'b1);
    chk("b2b_rdata4", bus.ufp_rdata, 32'h2222_2222);

    // conflict miss on 0x2040, same set 2
    @(negedge clk0);
    bus.ufp_req = 1'b1; bus.ufp_addr = 32'h0000_2040;
    #1;
    chk("cf_idle_resp", bus.ufp_resp, 1'b0);
    chk("cf_idle_ready", bus.ufp_ready, 1'b1);
    @(negedge clk0);
    bus.ufp_req = 1'b0;
    #1;
    chk("cf_dfp_read", bus.dfp_read, 1'b1);
    chk("cf_dfp_addr", bus.dfp_addr, 32'h0000_2040);
    beat(64'hAAAA0001_AAAA0000);
    beat(64'hAAAA0003_AAAA0002);
    beat(64'hAAAA0005_AAAA0004);
    beat(64'hAAAA0007_AAAA0006);
    @(negedge clk0);
    bus.dfp_rvalid = 1'b0;
    bus.ufp_req = 1'b1; bus.ufp_addr = 32'h0000_1040;
    #1;
    chk("cf_wr_tag", bus.arr_tag_din, 23'h000010);
    chk("cf_wr_data", bus.arr_data_din, LINE_B);
    chk("cf_wr_rdata", bus.ufp_rdata, 32'hAAAA_0000);
    chk("cf_wr_ready", bus.ufp_ready, 1'b1);
    @(negedge clk0);
    bus.ufp_req = 1'b0;
    #1;
    chk("cf_remiss_ready", bus.ufp_ready, 1'b0);
    chk("cf_remiss_resp", bus.ufp_resp, 1'b0);
    chk("cf_remiss_addr", bus.dfp_addr, 32'h0000_1040);

    // reset after two beats
    beat(64'h11111111_11110000);
    beat(64'h22222222_22220000);
    @(negedge clk0);
    bus.dfp_rvalid = 1'b0;
    rst0_n = 1'b0;
    #1;
    chk("mid_rst_dfp_read", bus.dfp_read, 1'b0);
    chk("mid_rst_ready", bus.ufp_ready, 1'b1);
    chk("mid_rst_csb", bus.arr_csb, 1'b1);
    @(negedge clk0);
    rst0_n = 1'b1;

    // retry 0x1040 refills correctly
    @(negedge clk0);
    bus.ufp_req = 1'b1; bus.ufp_addr = 32'h0000_1040;
    #1;
    chk("retry_csb", bus.arr_csb, 1'b0);
    @(negedge clk0);
    bus.ufp_req = 1'b0;
    #1;
    chk("retry_dfp_read", bus.dfp_read, 1'b1);
    chk("retry_dfp_addr", bus.dfp_addr, 32'h0000_1040);
    beats_a();
    @(negedge clk0);
    bus.dfp_rvalid = 1'b0;
    #1;
    chk("retry_wr_data", bus.arr_data_din, LINE_A);
    chk("retry_wr_tag", bus.arr_tag_din, 23'h000008);
    chk("retry_wr_rdata", bus.ufp_rdata, 32'h1111_0000);
    @(negedge clk0);
    bus.ufp_req = 1'b1; bus.ufp_addr = 32'h0000_105C;
    #1;
    @(negedge clk0);
    bus.ufp_req = 1'b0;
    #1;
    chk("retry_hit_resp", bus.ufp_resp, 1'b1);
    chk("retry_hit_rdata", bus.ufp_rdata, 32'h4444_4444);
    chk("retry_hit_dfp_read", bus.dfp_read, 1'b0);

`ifdef INST_CACHE_FLUSH_EN
    // flush sweeps all 16 sets, then set 2 misses
    @(negedge clk0);
    flush = 1'b1;
    #1;
    chk("fl_idle_ready", bus.ufp_ready, 1'b0);
    @(negedge clk0);
    flush = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("fl_ready", bus.ufp_ready, 1'b0);
      chk("fl_web", bus.arr_web, 1'b0);
      chk("fl_idx", bus.arr_addr, k[3:0]);
      chk("fl_valid", bus.arr_valid_din, 1'b0);
      @(negedge clk0);
    end
    bus.ufp_req = 1'b1; bus.ufp_addr = 32'h0000_1040;
    #1;
    chk("fl_after_ready", bus.ufp_ready, 1'b1);
    @(negedge clk0);
    bus.ufp_req = 1'b0;
    #1;
    chk("fl_miss_dfp_read", bus.dfp_read, 1'b1);
    chk("fl_miss_resp", bus.ufp_resp, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
